// File: rtl/mutex_req_ctrl.sv
// mutex_req_ctrl
// Clocked request/grant controller wrapped around a two-input asynchronous
// mutex element. Each channel registers its client request onto the mutex
// R input, synchronises the mutex A output into clk, and runs a 4-phase
// return-to-zero handshake toward its client. Both synchronised grants
// being high together latches a sticky violation flag.
//
// Optional build macro: MUTEX_REQ_CTRL_TIMEOUT_EN
//   defined   : per-channel hold counter; a grant held for HOLD_MAX cycles
//               is force-released and the client must drop its request
//               before it can request again.
//   undefined : no counter, grants are held indefinitely, timeout outputs
//               are tied low.

// ---------------------------------------------------------------------------
// mutex_req_chan: one request/grant channel
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_IDLE      | R=0 gnt=0, waiting for the client request
//   ST_REQ       | R=1, waiting for the synchronised mutex grant
//   ST_GRANT     | R=1 gnt=1, client owns the resource
//   ST_RELEASE   | R=0 gnt=0, waiting for the synchronised grant to fall
//   ST_WAIT_DROP | R=0 gnt=0, after a forced release, waiting for req=0
// ---------------------------------------------------------------------------
module mutex_req_chan #(
    parameter int SYNC_STAGES = 2
`ifdef MUTEX_REQ_CTRL_TIMEOUT_EN
    ,
    parameter int HOLD_MAX    = 64,
    parameter int CNT_W       = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic a_i,
    output logic r_o,
    output logic gnt_o,
    output logic a_sync_o,
    output logic timeout_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_GRANT     = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_WAIT_DROP = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   a_sync;
    logic                   hold_expired;
    logic                   tmo_rel;

    // Grant synchroniser: shift the asynchronous mutex grant into clk.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], a_i};
    end

    assign a_sync = sync_q[SYNC_STAGES-1];

`ifdef MUTEX_REQ_CTRL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tmo_rel_q;
    logic             tmo_rel_d;
    logic             timeout_q;
    logic             timeout_d;

    // Hold counter: zero outside GRANT, so the first GRANT cycle sees 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_GRANT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The HOLD_MAX-th GRANT cycle is the one where the count reads HOLD_MAX-1.
    assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX - 1));

    // Forced release: one-cycle pulse aligned with the first RELEASE cycle;
    // the cause is remembered for the whole RELEASE stay so the exit can
    // route through WAIT_DROP.
    always_comb begin
        timeout_d = (state_q == ST_GRANT) && req_i && hold_expired;
        tmo_rel_d = 1'b0;
        if (timeout_d) begin
            tmo_rel_d = 1'b1;
        end else if (state_q == ST_RELEASE) begin
            tmo_rel_d = tmo_rel_q;
        end
    end

    // Timeout-path registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tmo_rel_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_rel_q <= tmo_rel_d;
            timeout_q <= timeout_d;
        end
    end

    assign tmo_rel   = tmo_rel_q;
    assign timeout_o = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign tmo_rel      = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // Next-state logic. A request dropped in REQ is not aborted: the mutex
    // may already have granted, so the channel takes the grant and then
    // releases it rather than leaving a grant orphaned.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (a_sync) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req_i || hold_expired) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!a_sync) begin
                    state_d = (tmo_rel && req_i) ? ST_WAIT_DROP : ST_IDLE;
                end
            end
            ST_WAIT_DROP: begin
                if (!req_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and synchroniser registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
        end
    end

    // Moore outputs decoded from registered state only.
    assign r_o      = (state_q == ST_REQ) || (state_q == ST_GRANT);
    assign gnt_o    = (state_q == ST_GRANT);
    assign a_sync_o = a_sync;

    // Sanity properties on the channel.
    a_gnt_has_r : assert property (@(posedge clk) disable iff (rst)
        gnt_o |-> r_o);
    a_tmo_pulse : assert property (@(posedge clk) disable iff (rst)
        timeout_o |=> !timeout_o);

endmodule

// ---------------------------------------------------------------------------
// mutex_req_ctrl: two independent channels plus the violation flag
// ---------------------------------------------------------------------------
module mutex_req_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_MAX    = 64,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req1_i,
    input  logic req2_i,
    output logic gnt1_o,
    output logic gnt2_o,
    output logic R1,
    output logic R2,
    input  logic A1,
    input  logic A2,
    output logic err_o,
    output logic timeout1_o,
    output logic timeout2_o
);

    // Reject parameter sets the synchroniser or hold counter cannot support.
    if (SYNC_STAGES < 2 || HOLD_MAX < 2 || (2 ** CNT_W) <= HOLD_MAX) begin : g_param_check
        $error("mutex_req_ctrl: illegal SYNC_STAGES/HOLD_MAX/CNT_W combination");
    end

    logic a1_sync;
    logic a2_sync;
    logic err_q;
    logic err_d;

    mutex_req_chan #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef MUTEX_REQ_CTRL_TIMEOUT_EN
        ,
        .HOLD_MAX    (HOLD_MAX),
        .CNT_W       (CNT_W)
`endif
    ) u_chan1 (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req1_i),
        .a_i       (A1),
        .r_o       (R1),
        .gnt_o     (gnt1_o),
        .a_sync_o  (a1_sync),
        .timeout_o (timeout1_o)
    );

    mutex_req_chan #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef MUTEX_REQ_CTRL_TIMEOUT_EN
        ,
        .HOLD_MAX    (HOLD_MAX),
        .CNT_W       (CNT_W)
`endif
    ) u_chan2 (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req2_i),
        .a_i       (A2),
        .r_o       (R2),
        .gnt_o     (gnt2_o),
        .a_sync_o  (a2_sync),
        .timeout_o (timeout2_o)
    );

    // Sticky violation: both synchronised grants high in the same cycle.
    always_comb begin
        err_d = err_q | (a1_sync & a2_sync);
    end

    // Violation flag register; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_mutex_req_ctrl.sv
// Self-checking bench for mutex_req_ctrl with a behavioural mutex model.
// Output vector layout: {R1, R2, gnt1_o, gnt2_o, err_o, timeout1_o, timeout2_o}.
module tb_mutex_req_ctrl;

    localparam int S  = 2;
    localparam int HM = 4;

    logic clk = 1'b0;
    logic rst;
    logic req1_i;
    logic req2_i;
    logic gnt1_o;
    logic gnt2_o;
    logic R1;
    logic R2;
    logic A1;
    logic A2;
    logic err_o;
    logic timeout1_o;
    logic timeout2_o;

    logic g1 = 1'b0;
    logic g2 = 1'b0;
    logic force_both;
    logic prefer2;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];

    wire [6:0] obs = {R1, R2, gnt1_o, gnt2_o, err_o, timeout1_o, timeout2_o};

    mutex_req_ctrl #(
        .SYNC_STAGES (S),
        .HOLD_MAX    (HM),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req1_i     (req1_i),
        .req2_i     (req2_i),
        .gnt1_o     (gnt1_o),
        .gnt2_o     (gnt2_o),
        .R1         (R1),
        .R2         (R2),
        .A1         (A1),
        .A2         (A2),
        .err_o      (err_o),
        .timeout1_o (timeout1_o),
        .timeout2_o (timeout2_o)
    );

    always #5 clk = ~clk;

    // Behavioural mutex: grants at most one requester, reacts shortly after R changes.
    always @(R1 or R2) begin
        #2;
        if (R1 !== 1'b1) g1 = 1'b0;
        if (R2 !== 1'b1) g2 = 1'b0;
        if (!g1 && !g2) begin
            if (R1 === 1'b1 && R2 === 1'b1) begin
                if (prefer2) g2 = 1'b1;
                else         g1 = 1'b1;
            end else if (R1 === 1'b1) begin
                g1 = 1'b1;
            end else if (R2 === 1'b1) begin
                g2 = 1'b1;
            end
        end
    end

    assign A1 = g1 | force_both;
    assign A2 = g2 | force_both;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        req1_i = 1'b0;
        req2_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        exp_t x;
        rst = 1'b1;
        repeat (2) tick();
        x.tag = "reset_held";
        x.val = 7'b0000000;
        sb.push_back(x);
        x = sb.pop_front();
        compared++;
        if (obs !== x.val) begin
            mismatched++;
            $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
        end
        rst = 1'b0;
        x.tag = "reset_released_idle";
        x.val = 7'b0000000;
        sb.push_back(x);
        tick();
        x = sb.pop_front();
        compared++;
        if (obs !== x.val) begin
            mismatched++;
            $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
        end
    endtask

    task automatic test_single_grant();
        exp_t x;
        req1_i = 1'b1;
        req2_i = 1'b0;
        for (int e = 0; e <= S + 3; e++) begin
            x.tag = $sformatf("single_grant_e%0d", e);
            x.val = {1'b1, 1'b0, (e >= S + 1), 1'b0, 1'b0, 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
    endtask

    // Channel 1 is in GRANT on entry; drop at edge k (j=0), re-raise for k+1.
    task automatic test_release_rerequest();
        exp_t x;
        req1_i = 1'b0;
        for (int j = 0; j <= 2 * S + 3; j++) begin
            x.tag = $sformatf("rerequest_k%0d", j);
            x.val = {(j >= S + 2), 1'b0, (j >= 2 * S + 3), 1'b0, 1'b0, 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
            req1_i = 1'b1;
        end
        drain(6);
    endtask

    task automatic test_contention();
        exp_t x;
        prefer2 = 1'b1;
        req1_i  = 1'b1;
        req2_i  = 1'b1;
        for (int e = 0; e <= 15; e++) begin
            if (e >= 10) req2_i = 1'b0;
            x.tag = $sformatf("contention_e%0d", e);
            x.val = {1'b1, (e < 10), (e >= 10 + S + 1), (e >= S + 1 && e < 10),
                     1'b0, 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
        drain(6);
        prefer2 = 1'b0;
    endtask

    task automatic test_drop_in_req();
        exp_t x;
        req1_i = 1'b1;
        for (int e = 0; e <= S + 4; e++) begin
            if (e >= 1) req1_i = 1'b0;
            x.tag = $sformatf("drop_in_req_e%0d", e);
            x.val = {(e <= S + 1), 1'b0, (e == S + 1), 1'b0, 1'b0, 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
        drain(6);
    endtask

    // Both grants forced for one cycle; the first sampling edge is j=1.
    task automatic test_err();
        exp_t x;
        force_both = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            x.tag = $sformatf("err_j%0d", j);
            x.val = {1'b0, 1'b0, 1'b0, 1'b0, (j >= 3), 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            force_both = 1'b0;
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
    endtask

    // Reset mid-GRANT with err still latched, then a fresh request.
    task automatic test_reset_mid_grant();
        exp_t x;
        req1_i = 1'b1;
        for (int e = 0; e <= S + 1; e++) begin
            x.tag = $sformatf("pre_rst_grant_e%0d", e);
            x.val = {1'b1, 1'b0, (e >= S + 1), 1'b0, 1'b1, 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
        rst = 1'b1;
        x.tag = "rst_mid_grant";
        x.val = 7'b0000000;
        sb.push_back(x);
        tick();
        rst = 1'b0;
        x = sb.pop_front();
        compared++;
        if (obs !== x.val) begin
            mismatched++;
            $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
        end
        for (int e = 0; e <= S + 2; e++) begin
            x.tag = $sformatf("post_rst_grant_e%0d", e);
            x.val = {1'b1, 1'b0, (e >= S + 1), 1'b0, 1'b0, 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
        drain(6);
    endtask

    task automatic test_timeout();
        exp_t x;
        req1_i = 1'b1;
`ifdef MUTEX_REQ_CTRL_TIMEOUT_EN
        // Grant after edge S+1, held HM cycles, forced release with a pulse,
        // then WAIT_DROP until req1 drops at edge 13; re-request at edge 14.
        for (int e = 0; e <= 14; e++) begin
            if (e == 13) req1_i = 1'b0;
            if (e == 14) req1_i = 1'b1;
            x.tag = $sformatf("timeout_e%0d", e);
            x.val = {(e <= S + HM) || (e == 14), 1'b0,
                     (e >= S + 1 && e <= S + HM), 1'b0, 1'b0,
                     (e == S + HM + 1), 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
        drain(10);
`else
        for (int e = 0; e <= 19; e++) begin
            x.tag = $sformatf("no_timeout_e%0d", e);
            x.val = {1'b1, 1'b0, (e >= S + 1), 1'b0, 1'b0, 1'b0, 1'b0};
            sb.push_back(x);
            tick();
            x = sb.pop_front();
            compared++;
            if (obs !== x.val) begin
                mismatched++;
                $display("FAIL %s: observed %b expected %b", x.tag, obs, x.val);
            end
        end
        drain(6);
`endif
    endtask

    initial begin
        rst        = 1'b1;
        req1_i     = 1'b0;
        req2_i     = 1'b0;
        force_both = 1'b0;
        prefer2    = 1'b0;
        test_reset();
        test_single_grant();
        test_release_rerequest();
        test_contention();
        test_drop_in_req();
        test_err();
        test_reset_mid_grant();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mutex_req_ctrl.md
# mutex_req_ctrl

Clocked request/grant controller wrapped around the two-input asynchronous mutex element. It registers two client requests into the mutex `R1`/`R2` inputs, synchronises the mutex `A1`/`A2` grant outputs into the clock domain, and runs a 4-phase return-to-zero handshake per channel toward the clients. It also flags mutual-exclusion violations and, optionally, force-releases a channel that holds its grant too long.

## Interface

- `SYNC_STAGES`, 2: flops per grant synchroniser, minimum 2.
- `HOLD_MAX`, 64: maximum consecutive GRANT cycles before forced release (timeout build only), minimum 2.
- `CNT_W`, 8: hold-counter width; must satisfy 2^CNT_W > HOLD_MAX.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req1_i`, `req2_i`  in  1 each  client requests (level, 4-phase).
- `gnt1_o`, `gnt2_o`  out  1 each  client grants (registered).
- `R1`, `R2`  out  1 each  registered requests to the mutex.
- `A1`, `A2`  in  1 each  asynchronous grants from the mutex.
- `err_o`  out  1  sticky mutual-exclusion violation.
- `timeout1_o`, `timeout2_o`  out  1 each  one-cycle forced-release pulse.

## Operation

- Channels 1 and 2 are identical and independent. Each has its own FSM, synchroniser and (optionally) hold counter.
- FSM states:
  - IDLE: `R`=0, `gnt`=0. Moves to REQ when `req_i`=1.
  - REQ: `R`=1. Moves to GRANT when synced `A`=1.
  - GRANT: `R`=1, `gnt`=1. Moves to RELEASE when `req_i`=0, or on timeout.
  - RELEASE: `R`=0, `gnt`=0. When synced `A`=0, moves to IDLE, or to WAIT_DROP if the release was a timeout and `req_i` is still 1.
  - WAIT_DROP: `R`=0, `gnt`=0. Moves to IDLE when `req_i`=0.
- `R` and `gnt` are Moore outputs decoded from registered state. No combinational path exists from `A` or `req_i` to any output.
- Dropping `req_i` in REQ does not abort the request. The channel waits for the grant, enters GRANT, then releases on the following cycle. This prevents a mutex grant from being orphaned.
- Contention is resolved by the mutex only; this block adds no priority.
- `err_o` is set when both synced grants are 1 in the same cycle. It stays set until `rst`.
- Reset: every FSM goes to IDLE; `R1`=`R2`=0, `gnt1_o`=`gnt2_o`=0, `err_o`=0, `timeout*_o`=0; synchronisers and counters are cleared.
  - Reset mid-GRANT drops `R` at the next edge, so the mutex releases asynchronously. No handshake completion is owed to the client.

## Timing

- Edge 0 is the edge that samples `req_i`=1 in IDLE.
- Uncontested grant latency is SYNC_STAGES+1 edges:
  - `R` is high after edge 0.
  - The synced `A` is high after edge SYNC_STAGES.
  - `gnt_o` is high after edge SYNC_STAGES+1 (edge 3 at the default).
- Release, with edge k sampling `req_i`=0 in GRANT:
  - `R` and `gnt_o` are low after edge k.
  - IDLE is reached after edge k+SYNC_STAGES+1.
  - The earliest re-assertion of `R` is after edge k+SYNC_STAGES+2.
- Contended case: the losing channel stays in REQ with `R`=1. Its grant arrives SYNC_STAGES+1 edges after the winner's `R` falls.
- Simultaneous `req1_i`/`req2_i` in the same cycle: both `R` rise on the same edge, and exactly one grant results.
- `err_o` asserts on the edge after the violating synced sample.

## Configuration

- `MUTEX_REQ_CTRL_TIMEOUT_EN` defined:
  - The hold counter is cleared on GRANT entry and increments each GRANT cycle.
  - At the HOLD_MAX-th consecutive GRANT cycle with `req_i`=1, the FSM moves to RELEASE and `timeout_o` pulses for exactly one cycle, coincident with the first RELEASE cycle.
  - The channel then passes through WAIT_DROP and cannot re-request until the client drops `req_i`.
- Not defined:
  - There is no counter and WAIT_DROP is unreachable.
  - `timeout1_o`/`timeout2_o` are tied to 0, and grants are held indefinitely.

## Test plan

- Reset then `req1_i`=1 at edge 0, with a behavioural mutex model: `R1`=1 after edge 0 and `gnt1_o`=1 after edge 3; `gnt2_o`, `R2` and `err_o` stay 0.
- `req1_i` and `req2_i` rise together, model grants channel 2: `gnt2_o` after edge 3. Drop `req2_i` at edge 10: `R2`=0 after edge 10, `gnt1_o`=1 after edge 13, `gnt2_o` never overlaps `gnt1_o`.
- Release and re-request: `req1_i` low at edge k, high again at k+1: `R1` stays 0 until after edge k+4.
- Force `A1`=`A2`=1 for one cycle: `err_o`=1 two edges later and stays 1 until `rst`; `rst` clears it along with both grants.
- Timeout build, HOLD_MAX=4, `req1_i` held high: `gnt1_o` is high for exactly 4 cycles, then `timeout1_o` pulses once; `R1` stays 0 until `req1_i` drops and is re-asserted. Non-timeout build: `gnt1_o` remains high.
- Assert `rst` while channel 1 is in GRANT: `R1`=0 and `gnt1_o`=0 after that edge; a new request after reset gets the normal SYNC_STAGES+1 latency.
